// File: rtl/axi_mst_write_pipe_if.sv
// axi_mst_write_pipe_if: AXI4 write channels plus the AXIS feed of the streaming write master
interface axi_mst_write_pipe_if #(parameter int ID_WIDTH = 1, parameter int DATA_WIDTH = 64);
  logic [ID_WIDTH-1:0] awid;
  logic [31:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awlock;
  logic [3:0] awcache;
  logic [2:0] awprot;
  logic [3:0] awregion, awqos;
  logic awvalid, awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic wlast, wvalid, wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic tlast, tvalid, tready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awregion, awqos, awvalid,
    input awready,
    output wdata, wstrb, wlast, wvalid,
    input wready,
    input bid, bresp, bvalid,
    output bready,
    input tdata, tstrb, tlast, tvalid,
    output tready
  );
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awregion, awqos, awvalid,
    output awready,
    input wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input bready,
    output tdata, tstrb, tlast, tvalid,
    input tready
  );
endinterface

// File: rtl/axi_mst_write_pipe.sv
// axi_mst_write_pipe: streams AXIS beats into memory as a run of INCR bursts with decoupled AW/W/B
module axi_mst_write_pipe #(
  parameter int ID_WIDTH = 1,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk,
  input logic rstn,
  input logic trigger,
  axi_mst_write_pipe_if.master bus,
  input logic START_REG,
  input logic TRIG_EN_REG,
  input logic [31:0] ADDR_REG,
  input logic [7:0] LEN_REG,
  input logic [31:0] NBURST_REG,
  output logic BUSY_REG,
  output logic DONE_REG,
  output logic [1:0] ERR_REG,
  output logic [31:0] BCNT_REG
);
  localparam int SIZE = $clog2(DATA_WIDTH/8);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] start_s, trig_s;
  logic start_d;
  logic [31:0] addr, nburst, aw_cnt, w_burst_cnt, bcnt;
  logic [7:0] len, beat_cnt;
  logic [3:0] outstanding;
  logic [1:0] err;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic run, arm_go, empty, full, aw_hs, w_hs, b_hs, t_hs;
  logic unused;
  assign unused = ^{bus.bid, bus.tstrb, bus.tlast};
  assign run = state == RUN;
  assign arm_go = state == ARM && (!TRIG_EN_REG || trig_s[1]);
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (start_s[1] && !start_d) ? ARM : IDLE;
      ARM: state_nx = arm_go ? RUN : ARM;
      RUN: state_nx = (bcnt == nburst) ? DONE : RUN;
      default: state_nx = (!start_s[1] && !(TRIG_EN_REG && trig_s[1])) ? IDLE : DONE;
    endcase
  end
  assign bus.awid = '0;
  assign bus.awaddr = addr;
  assign bus.awlen = len;
  assign bus.awsize = 3'(SIZE);
  assign bus.awburst = 2'b01;
  assign bus.awlock = 1'b0;
  assign bus.awcache = 4'b0011;
  assign bus.awprot = 3'b010;
  assign bus.awregion = 4'd0;
  assign bus.awqos = 4'd0;
  assign bus.awvalid = run && aw_cnt < nburst && outstanding < 4'(MAX_OUTSTANDING);
  // data for a burst is held back until its address has been accepted
  assign bus.wvalid = run && !empty && w_burst_cnt < aw_cnt;
  assign bus.wdata = mem[rp[AW-1:0]];
  assign bus.wstrb = '1;
  assign bus.wlast = beat_cnt == len;
  assign bus.bready = run;
  assign bus.tready = !full;
  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs = bus.wvalid && bus.wready;
  assign b_hs = bus.bvalid && run;
  assign t_hs = bus.tvalid && !full;
  assign ERR_REG = err;
  assign BCNT_REG = bcnt;
  always_ff @(posedge clk)
    if (t_hs) mem[wp[AW-1:0]] <= bus.tdata;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      start_s <= 2'b00;
      trig_s <= 2'b00;
      start_d <= 1'b0;
      BUSY_REG <= 1'b0;
      DONE_REG <= 1'b0;
      wp <= '0;
      rp <= '0;
      addr <= 32'd0;
      len <= 8'd0;
      nburst <= 32'd0;
      aw_cnt <= 32'd0;
      w_burst_cnt <= 32'd0;
      beat_cnt <= 8'd0;
      bcnt <= 32'd0;
      outstanding <= 4'd0;
      err <= 2'b00;
    end else begin
      state <= state_nx;
      start_s <= {start_s[0], START_REG};
      trig_s <= {trig_s[0], trigger};
      start_d <= start_s[1];
      BUSY_REG <= state_nx == ARM || state_nx == RUN;
      DONE_REG <= state_nx == DONE;
      if (t_hs) wp <= wp + (AW+1)'(1);
      if (w_hs) rp <= rp + (AW+1)'(1);
      if (arm_go) begin
        addr <= ADDR_REG;
        len <= LEN_REG;
        nburst <= NBURST_REG;
        aw_cnt <= 32'd0;
        w_burst_cnt <= 32'd0;
        beat_cnt <= 8'd0;
        bcnt <= 32'd0;
        outstanding <= 4'd0;
        err <= 2'b00;
      end else begin
        if (aw_hs) addr <= addr + ((32'(len) + 32'd1) << SIZE);
        if (aw_hs) aw_cnt <= aw_cnt + 32'd1;
        if (w_hs) beat_cnt <= bus.wlast ? 8'd0 : beat_cnt + 8'd1;
        if (w_hs && bus.wlast) w_burst_cnt <= w_burst_cnt + 32'd1;
        if (b_hs) bcnt <= bcnt + 32'd1;
        if (b_hs && err == 2'b00) err <= bus.bresp;
        if (aw_hs != b_hs) outstanding <= aw_hs ? outstanding + 4'd1 : outstanding - 4'd1;
      end
    end
endmodule

// File: tb/tb_axi_mst_write_pipe.sv
// tb_axi_mst_write_pipe: scoreboard bench driving AXIS beats and modelling the AXI write slave
module tb_axi_mst_write_pipe;
  localparam int DW = 64;
  localparam int MAXO = 2;
  logic clk = 1'b0, rstn = 1'b0, trigger = 1'b0, start = 1'b0, trig_en = 1'b0;
  logic [31:0] addr_reg = 32'd0, nburst_reg = 32'd0;
  logic [7:0] len_reg = 8'd0;
  logic busy, done;
  logic [1:0] err;
  logic [31:0] bcnt;
  int n_chk = 0, n_err = 0;
  logic [DW-1:0] exp_q [$];
  int n_send = 0, sent = 0, aw_n = 0, b_n = 0, w_n = 0, wb_n = 0, beat = 0;
  int aw_run = 0, b_run = 0, vld_cyc = 0, b_pend = 0, mx = 0, aw0 = 0, w0 = 0, v0 = 0;
  bit b_fire = 0, t_fire = 0, rnd = 0, b_block = 0, err_mode = 0;

  axi_mst_write_pipe_if #(.ID_WIDTH(1), .DATA_WIDTH(DW)) bus ();
  axi_mst_write_pipe #(.ID_WIDTH(1), .DATA_WIDTH(DW), .FIFO_DEPTH(32), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rstn(rstn), .trigger(trigger), .bus(bus),
    .START_REG(start), .TRIG_EN_REG(trig_en), .ADDR_REG(addr_reg), .LEN_REG(len_reg),
    .NBURST_REG(nburst_reg), .BUSY_REG(busy), .DONE_REG(done), .ERR_REG(err), .BCNT_REG(bcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic bit ok();
    return !rnd || ($urandom_range(3) != 0);
  endfunction

  function automatic logic [DW-1:0] gen(input int i);
    return {32'(i) * 32'h9E3779B1, 32'h5A5A0000 ^ 32'(i)};
  endfunction

  // one cycle of the slave/producer model, evaluated on the falling edge
  task automatic step();
    @(negedge clk);
    if (!rstn) begin
      exp_q.delete();
      {bus.awready, bus.wready, bus.bvalid, bus.tvalid} = 4'b0;
      bus.bresp = 2'b00;
      b_pend = 0; b_fire = 0; t_fire = 0; beat = 0;
      b_n = aw_n; wb_n = aw_n; aw_run = 0; b_run = 0;
    end else begin
      if (!busy) begin aw_run = 0; b_run = 0; end
      if (bus.awvalid || bus.wvalid) vld_cyc++;
      if (b_fire) begin b_n++; b_run++; b_pend--; end
      if (!bus.bvalid || b_fire) bus.bvalid = b_pend > 0 && !b_block && ok();
      bus.bresp = (err_mode && b_run == 2) ? 2'b10 : (err_mode && b_run == 4) ? 2'b11 : 2'b00;
      bus.awready = ok();
      bus.wready = ok();
      if (bus.wvalid && bus.wready) begin
        chk("w_after_aw", wb_n < aw_n, 1);
        if (exp_q.size() == 0) chk("wdata_extra", 1, 0);
        else chk("wdata", bus.wdata, exp_q.pop_front());
        chk("wlast", bus.wlast, beat == int'(len_reg));
        w_n++;
        if (beat == int'(len_reg)) begin beat = 0; wb_n++; b_pend++; end
        else beat++;
      end
      if (bus.awvalid && bus.awready) begin
        chk("awaddr", bus.awaddr, addr_reg + 32'(aw_run) * (32'(len_reg) + 32'd1) * 32'd8);
        chk("awlen", bus.awlen, len_reg);
        chk("aw_in_range", 32'(aw_run) < nburst_reg, 1);
        aw_n++; aw_run++;
      end
      b_fire = bus.bvalid && bus.bready;
      if (!bus.tvalid || t_fire) begin
        bus.tvalid = sent < n_send && ok();
        bus.tdata = gen(sent);
      end
      t_fire = bus.tvalid && bus.tready;
      if (t_fire) begin exp_q.push_back(bus.tdata); sent++; end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) step();
  endtask

  task automatic run_test(input logic [31:0] a, input logic [7:0] l, input int nb, input int hold);
    addr_reg = a; len_reg = l; nburst_reg = 32'(nb); trig_en = 1'b0;
    aw0 = aw_n; w0 = w_n; mx = 0;
    b_block = hold > 0;
    start = 1'b1;
    for (int i = 0; i < 20000 && !done; i++) begin
      if (i == hold) b_block = 0;
      step();
      if (aw_n - b_n - int'(b_fire) > mx) mx = aw_n - b_n - int'(b_fire);
    end
    b_block = 0;
    chk("done", done, 1);
    chk("busy_at_done", busy, 0);
    chk("bcnt", bcnt, 64'(nb));
    chk("aw_total", aw_n - aw0, nb);
    chk("w_total", w_n - w0, nb * (int'(l) + 1));
    chk("scoreboard_empty", exp_q.size(), 0);
    start = 1'b0;
    tick(6);
    chk("back_to_idle", done, 0);
  endtask

  initial begin
    {bus.awready, bus.wready, bus.bvalid, bus.tvalid, bus.tlast} = 5'b0;
    bus.bid = '0; bus.bresp = 2'b00; bus.tstrb = '1; bus.tdata = '0;
    tick(3);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bcnt", bcnt, 0);
    chk("rst_tready", bus.tready, 1);
    rstn = 1'b1;
    // basic: prefill exactly the FIFO depth, then four 8-beat bursts
    n_send = sent + 32;
    tick(40);
    chk("fifo_full", bus.tready, 0);
    run_test(32'h1000, 8'd7, 4, 0);
    chk("basic_err", err, 0);
    // outstanding limit with B held back
    n_send = sent + 24;
    tick(30);
    run_test(32'h2000, 8'd3, 6, 50);
    chk("max_outstanding", mx, MAXO);
    // random backpressure on every channel
    rnd = 1;
    n_send = sent + 160;
    run_test(32'h20000, 8'd15, 10, 0);
    rnd = 0;
    chk("bp_err", err, 0);
    // sticky error keeps the first non-OKAY response
    err_mode = 1;
    n_send = sent + 12;
    run_test(32'h3000, 8'd1, 6, 0);
    err_mode = 0;
    chk("err_sticky", err, 2'b10);
    // trigger wait with zero bursts
    trig_en = 1'b1; nburst_reg = 32'd0; addr_reg = 32'h6000; len_reg = 8'd3;
    v0 = vld_cyc;
    start = 1'b1;
    tick(10);
    chk("arm_busy", busy, 1);
    chk("arm_not_done", done, 0);
    trigger = 1'b1;
    tick(8);
    chk("trig_done", done, 1);
    chk("zero_bcnt", bcnt, 0);
    chk("zero_no_valid", vld_cyc - v0, 0);
    start = 1'b0;
    tick(6);
    chk("hold_done_trig_high", done, 1);
    trigger = 1'b0;
    tick(6);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    trig_en = 1'b0;
    // reset during the second burst, then a clean restart
    addr_reg = 32'h4000; len_reg = 8'd7; nburst_reg = 32'd8;
    n_send = sent + 64;
    tick(40);
    w0 = w_n;
    start = 1'b1;
    for (int i = 0; i < 500 && (w_n - w0) < 10; i++) step();
    chk("reached_burst2", (w_n - w0) >= 10, 1);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_bready", bus.bready, 1);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_awvalid", bus.awvalid, 0);
    chk("mid_rst_wvalid", bus.wvalid, 0);
    chk("mid_rst_bready", bus.bready, 0);
    chk("mid_rst_busy", busy, 0);
    start = 1'b0;
    tick(3);
    n_send = sent;
    rstn = 1'b1;
    tick(2);
    chk("post_rst_bcnt", bcnt, 0);
    chk("post_rst_tready", bus.tready, 1);
    n_send = sent + 32;
    tick(40);
    run_test(32'h5000, 8'd7, 4, 0);
    chk("restart_err", err, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/axi_mst_write_pipe.md
# axi_mst_write_pipe

Parametrised AXI4 write master that streams AXIS data into memory as a run of INCR bursts: one AXIS beat in, one AXI write beat out. It keeps up to MAX_OUTSTANDING bursts in flight, with the AW, W and B channels decoupled. Burst length is set at run time. It reports busy, done, completed-burst count and a sticky response error. It sits between an AXIS producer and the DDR interconnect in the bandwidth-test datapath, with registers driven from the AXI-Lite register bank.

## Interface
- ID_WIDTH, 1, width of AWID/BID; AWID is driven to 0.
- DATA_WIDTH, 64, AXI/AXIS data width in bits, power of 2 from 8 to 1024.
- FIFO_DEPTH, 32, input FIFO depth in beats, power of 2, at least 16.
- MAX_OUTSTANDING, 4, maximum number of issued bursts without a B response, 1..15.

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous, active-low reset.
- trigger  in  1  external start strobe; asynchronous, synchronised internally.
- m_axi_aw*  AW channel (awid, awaddr[31:0], awlen[7:0], awsize[2:0], awburst, awlock, awcache, awprot, awregion, awqos, awvalid out; awready in).
- m_axi_w*  W channel (wdata[DATA_WIDTH], wstrb[DATA_WIDTH/8], wlast, wvalid out; wready in).
- m_axi_b*  B channel (bid, bresp[1:0], bvalid in; bready out).
- s_axis_tdata/tstrb/tlast/tvalid  in; s_axis_tready  out  AXIS slave. tstrb and tlast are ignored.
- START_REG  in  1  level enable; synchronised internally.
- TRIG_EN_REG  in  1  1 = wait for trigger after START; 0 = run immediately.
- ADDR_REG  in  32  base byte address.
- LEN_REG  in  8  AWLEN, i.e. beats per burst minus 1.
- NBURST_REG  in  32  number of bursts; 0 is legal.
- BUSY_REG  out  1  run in progress.
- DONE_REG  out  1  run completed.
- ERR_REG  out  2  first non-OKAY BRESP of the run.
- BCNT_REG  out  32  bursts completed (B handshakes).

## Operation
- Constant AW fields: awsize = log2(DATA_WIDTH/8), awburst = INCR, awcache = 0011, awprot = 010, awlock/awregion/awqos = 0. wstrb is all ones.
- Software guarantees that ADDR_REG is aligned to (LEN_REG+1)*DATA_WIDTH/8. Software also guarantees that no burst crosses a 4 KB boundary. The block does not check either condition.
- FSM states:
  - IDLE: go to ARM on a synchronised START rising edge.
  - ARM: if TRIG_EN_REG=1, wait for the synchronised trigger to be high; otherwise leave after 1 cycle. In the same cycle, latch ADDR, LEN and NBURST, clear the counters and ERR, and go to RUN.
  - RUN: go to DONE when bcnt == nburst.
  - DONE: assert DONE_REG. Go to IDLE when START is low and (if TRIG_EN_REG=1) trigger is low.
- AW issue: awvalid = RUN & (aw_cnt < nburst) & (outstanding < MAX_OUTSTANDING). On handshake, addr += (len+1)*bytes and aw_cnt++. awaddr/awlen stay stable while awvalid is high.
- W issue: wvalid = RUN & FIFO not empty & (w_burst_cnt < aw_cnt). Data is never sent ahead of its address.
  - beat_cnt counts 0..len. wlast = (beat_cnt == len).
  - On a wlast handshake, beat_cnt returns to 0 and w_burst_cnt++.
- B: bready = RUN.
  - On each handshake: bcnt++ and outstanding--.
  - If ERR==00 and bresp!=00, ERR <= bresp (sticky).
  - AW handshake and B handshake in the same cycle leave outstanding unchanged.
- FIFO: first-word-fall-through. s_axis_tready = ~full. Writes occur on tvalid & tready. AXIS is accepted in every state, so data may prefill before RUN. Data left over at the end of a run stays queued for the next run.
- NBURST=0: the FSM goes ARM → RUN → DONE with no AXI traffic.

## Timing
- Reset values: awvalid, wvalid, bready, BUSY_REG, DONE_REG = 0; ERR_REG = 0; BCNT_REG = 0; FIFO empty; FSM in IDLE; all counters 0.
- Synchronisers: 2 flops, so START and trigger take 2 cycles to be seen.
- Run-start latency: the first awvalid is asserted in the cycle after ARM exits.
- wdata comes straight from the FWFT FIFO head, so back-to-back beats sustain 1 beat/cycle while the FIFO is non-empty and wready=1.
- AW may run up to MAX_OUTSTANDING bursts ahead of B. W may start in the cycle after the corresponding AW handshake.
- BUSY_REG = (state is ARM or RUN), registered.
- BCNT_REG updates the cycle after the B handshake.
- Deasserting START during RUN does not abort: the run completes, then the FSM waits in DONE.
- Reset mid-burst: all outputs return to reset values immediately and the FIFO is flushed. An AXI slave reset alongside the block is required.

## Test plan
- Basic: DATA_WIDTH=64, LEN=7, NBURST=4, ADDR=0x1000, TRIG_EN=0, slave always ready, 32 beats prefilled → awaddr 0x1000/0x1040/0x1080/0x10C0; wlast on every 8th beat; BCNT=4; DONE=1; ERR=0.
- Outstanding limit: MAX_OUTSTANDING=2, bvalid held off 50 cycles, NBURST=6 → never more than 2 AW handshakes ahead of B; all 6 bursts complete.
- Backpressure: random awready/wready/bvalid and AXIS tvalid gaps, LEN=15, NBURST=10 → 160 beats written in order with data matching the AXIS sequence; no beat is written before its AW.
- Error: 3rd BRESP=SLVERR (10), 5th BRESP=DECERR (11) → ERR_REG=10; the run still finishes with BCNT=NBURST.
- Trigger/zero: TRIG_EN=1, NBURST=0 → no AXI valids; DONE only after trigger; returns to IDLE once START and trigger are both low.
- Reset mid-run: rstn low during the 2nd burst → awvalid, wvalid, bready, BUSY drop asynchronously; a restart after reset completes cleanly.
